muldiv_seq: RTL and testbench

Iterative multi-cycle unsigned multiply/divide unit for the single-cycle MIPS-style datapath. It takes the 32-cycle multiply and divide work off the combinational ALU path. A shift-add / restoring-subtract datapath runs one step per clock under a small FSM, and results go into HI/LO registers that the CPU reads through mfhi/mflo. The CPU control stalls on busy_o.

---
 rtl/muldiv_seq.sv | 133 +++++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit for the MIPS-style datapath.
// One shift-add (multiply) or restoring-subtract (divide) step per clock;
// results land in HI/LO, which the CPU reads through mfhi/mflo while
// stalling on busy_o.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] cnt;
    logic             op_r;     // 0 = multiply, 1 = divide
    logic [WIDTH-1:0] opnd;     // multiplicand M or divisor D
    logic [WIDTH-1:0] acc_hi;   // product upper half or remainder R
    logic [WIDTH-1:0] acc_lo;   // product lower half or quotient Q

    logic             accept;
    logic             div_zero;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;   // upper half plus M, carry kept
    logic [WIDTH:0]   div_shift; // remainder after the left shift, one bit wider
    logic [WIDTH-1:0] div_sub;   // low bits of div_shift - D
    logic             div_ge;    // trial subtraction is non-negative
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign accept    = start_i && (state == IDLE || state == DONE);
    assign div_zero  = op_i && (src2_i == '0);
    assign last_iter = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));

    assign busy_o = (state == BUSY);
    assign done_o = (state == DONE);

    // Next-state decode for the IDLE/BUSY/DONE controller.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_i) state_next = div_zero ? DONE : BUSY;
                else         state_next = IDLE;
            end
            BUSY: begin
                if (last_iter) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One multiply or divide iteration computed from the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // The true difference is below 2^WIDTH whenever it is kept, so the low bits suffice.
        div_sub   = div_shift[WIDTH-1:0] - opnd;
        step_hi   = '0;
        step_lo   = '0;
        if (!op_r) begin
            // {carry, P} shifted right by one.
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (div_ge) begin
            step_hi = div_sub;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // State, operand latch, iteration registers and HI/LO result registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_i) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt    <= '0;
                op_r   <= op_i;
                acc_hi <= '0;
                if (op_i) begin
                    opnd   <= src2_i;  // divisor
                    acc_lo <= src1_i;  // dividend becomes Q
                end else begin
                    opnd   <= src1_i;  // multiplicand
                    acc_lo <= src2_i;  // multiplier in the low half of P
                end
                if (div_zero) begin
                    hi_o <= src1_i;
                    lo_o <= '1;
                end
            end else if (state == BUSY) begin
                cnt    <= cnt + 1'b1;
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (last_iter) begin
                    hi_o <= step_hi;
                    lo_o <= step_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations, with a queue-based scoreboard checked whenever done_o is high.
module tb_muldiv_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             op    = 1'b0;
    logic [WIDTH-1:0] src1  = '0;
    logic [WIDTH-1:0] src2  = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] mon_exp;
    logic [2*WIDTH-1:0] last_res = '0;

    muldiv_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .op_i   (op),
        .src1_i (src1),
        .src2_i (src2),
        .busy_o (busy),
        .done_o (done),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference result as {hi, lo}, straight from the arithmetic definition.
    function automatic logic [2*WIDTH-1:0] model(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] wa, wb;
        wa = {{WIDTH{1'b0}}, a};
        wb = {{WIDTH{1'b0}}, b};
        if (!o)         return wa * wb;
        else if (b == 0) return {a, {WIDTH{1'b1}}};
        else            return {a % b, a / b};
    endfunction

    function automatic int model_lat(input logic o, input logic [WIDTH-1:0] b);
        return (o && b == 0) ? 1 : LAT;
    endfunction

    // Scoreboard monitor: every done_o cycle retires the oldest expected result.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, required no done_o", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard_result", {hi, lo}, mon_exp);
            end
        end
    end

    // Called at a negedge: presents one start cycle and returns at the next negedge.
    task automatic start_op(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        src1  = $urandom;
        src2  = $urandom;
    endtask

    // Waits (bounded) for done_o; lat counts cycles from the start edge.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 3 * LAT) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o after %0d cycles, required done_o", lat);
        end
    endtask

    task automatic run_op(input string name, input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat, bc;
        start_op(o, a, b);
        wait_done(lat, bc);
        check({name, "_latency"}, lat, model_lat(o, b));
        check({name, "_result"}, {hi, lo}, model(o, a, b));
        last_res = model(o, a, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, bc;
        logic             ro;
        logic [WIDTH-1:0] ra, rb;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        rst = 1'b1;
        @(negedge clk);

        // 7*6: busy for WIDTH cycles, done after the start edge + WIDTH.
        start_op(1'b0, 32'd7, 32'd6);
        wait_done(lat, bc);
        check("mul7x6_latency", lat, LAT);
        check("mul7x6_busy_cycles", bc, WIDTH);
        check("mul7x6_result", {hi, lo}, 64'h0000_0000_0000_002A);
        @(negedge clk);
        check("mul7x6_done_one_cycle", done, 0);
        last_res = 64'h2A;

        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7);
        check("div_100_7_const", {hi, lo}, {32'd2, 32'd14});
        run_op("div_msb_1", 1'b1, 32'h8000_0000, 32'd1);
        check("div_msb_1_const", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op("div_3_10", 1'b1, 32'd3, 32'd10);
        check("div_3_10_const", {hi, lo}, {32'd3, 32'd0});

        // Divide by zero: immediate DONE, no BUSY cycles.
        @(negedge clk);
        start_op(1'b1, 32'd5, 32'd0);
        wait_done(lat, bc);
        check("div0_latency", lat, 1);
        check("div0_busy_cycles", bc, 0);
        check("div0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        last_res = {32'd5, 32'hFFFF_FFFF};
        @(negedge clk);

        // Start pulse mid-operation is ignored; HI/LO hold the old result.
        start_op(1'b0, 32'h0001_2345, 32'h0000_6789);
        repeat (9) @(negedge clk);
        check("busy_hold_result", {hi, lo}, last_res);
        op = 1'b1; src1 = 32'd99; src2 = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("ignored_start_result", {hi, lo}, 64'h0001_2345 * 64'h0000_6789);

        // Back-to-back: new divide accepted during the done cycle.
        start_op(1'b1, 32'd1_000_003, 32'd17);
        check("b2b_busy", busy, 1);
        wait_done(lat, bc);
        check("b2b_latency", lat, LAT);
        check("b2b_result", {hi, lo}, {32'd1_000_003 % 32'd17, 32'd1_000_003 / 32'd17});
        @(negedge clk);

        // Reset mid-multiply aborts with no result and no done_o.
        start_op(1'b0, 32'h0000_DEAD, 32'h0000_BEEF);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        repeat (LAT + 4) @(negedge clk);
        check("abort_hi_held", hi, 0);
        run_op("mul3x5", 1'b0, 32'd3, 32'd5);
        check("mul3x5_lo", lo, 32'd15);

        // Random operations, sometimes back-to-back, sometimes with idle gaps.
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = WIDTH'($urandom_range(1, 15));
                2: ra = 32'hFFFF_FFFF;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op("random", ro, ra, rb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
